// File: rtl/ddr3_word_bridge_pkg.sv
// Shared types and helpers for the 32-bit CPU to 128-bit Avalon DDR3 bridge.
package ddr3_bridge_pkg;

  localparam int unsigned CPU_W    = 32;
  localparam int unsigned CPU_BE_W = 4;
  localparam int unsigned LINE_W   = 128;
  localparam int unsigned LANE_W   = 2;
  localparam int unsigned BE_W     = 16;
  localparam int unsigned STATE_W  = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_WR_CMD  = 3'd1;
  localparam logic [STATE_W-1:0] ST_RD_CMD  = 3'd2;
  localparam logic [STATE_W-1:0] ST_RD_WAIT = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = ST_IDLE,
    WR_CMD  = ST_WR_CMD,
    RD_CMD  = ST_RD_CMD,
    RD_WAIT = ST_RD_WAIT,
    DONE    = ST_DONE
  } state_t;

  // Place a 4-bit word byte enable onto its lane of the 16-byte line.
  function automatic logic [BE_W-1:0] lane_be(input logic [CPU_BE_W-1:0] be,
                                              input logic [LANE_W-1:0] lane);
    return BE_W'(be) << {lane, 2'b00};
  endfunction

  // Extract one 32-bit word from a 128-bit line.
  function automatic logic [CPU_W-1:0] lane_word(input logic [LINE_W-1:0] line,
                                                 input logic [LANE_W-1:0] lane);
    return line[{lane, 5'b00000} +: CPU_W];
  endfunction

endpackage

// File: rtl/ddr3_word_bridge_if.sv
// CPU word-port and Avalon-MM bus interfaces used by ddr3_word_bridge.
interface cpu_word_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        done;
  logic [31:0] rdata;

  modport master (output valid, we, addr, wdata, be, input ready, done, rdata);
  modport slave  (input valid, we, addr, wdata, be, output ready, done, rdata);
endinterface

interface avl_mm_if #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned DATA_W = 128
);
  logic                  waitrequest;
  logic [ADDR_W-1:0]     address;
  logic                  write;
  logic                  read;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W/8-1:0]   byteenable;
  logic                  readdatavalid;
  logic [DATA_W-1:0]     readdata;

  modport master (input waitrequest, readdatavalid, readdata,
                  output address, write, read, writedata, byteenable);
  modport slave  (output waitrequest, readdatavalid, readdata,
                  input address, write, read, writedata, byteenable);
endinterface

// File: rtl/ddr3_word_bridge_line_buf.sv
// One-line read buffer (tag, 128-bit data, valid) with write-through byte merge.
// Compiled only when LINE_BUF_EN is defined.
`ifdef LINE_BUF_EN
module ddr3_line_buf
  import ddr3_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 26
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] lookup_tag,
  input  logic [ADDR_W-1:0] cmd_tag,
  input  logic              fill_en,
  input  logic [LINE_W-1:0] fill_data,
  input  logic              wr_en,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  output logic              hit_c,
  output logic [LINE_W-1:0] line_c
);

  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;
  logic [LINE_W-1:0] data_q;

  assign hit_c  = valid_q && (tag_q == lookup_tag);
  assign line_c = data_q;

  // Fill on read return; merge enabled bytes when a store to this line is accepted.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      tag_q   <= cmd_tag;
      data_q  <= fill_data;
    end else if (wr_en && valid_q && (tag_q == cmd_tag)) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (wr_be[b]) data_q[8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule
`endif

// File: rtl/ddr3_word_bridge.sv
// Single-outstanding 32-bit load/store to 128-bit Avalon-MM bridge for the DDR3 controller.
// Optional one-line read buffer enabled by defining LINE_BUF_EN.
module ddr3_word_bridge
  import ddr3_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned DATA_W = 128
) (
  input  logic     iCLK,
  input  logic     iRST,
  cpu_word_if.slave cpu,
  avl_mm_if.master  avl
);

  state_t            state;
  logic [LANE_W-1:0] lane_q;
  logic              hit_c;
  logic [LINE_W-1:0] buf_line;
  logic              unused_addr_bits;

  // Bytes within a word and address bits above the DDR3 window alias away.
  assign unused_addr_bits = ^{cpu.addr[CPU_W-1:ADDR_W+4], cpu.addr[1:0]};

`ifdef LINE_BUF_EN
  ddr3_line_buf #(.ADDR_W(ADDR_W)) u_line_buf (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .lookup_tag (cpu.addr[ADDR_W+3:4]),
    .cmd_tag    (avl.address),
    .fill_en    ((state == RD_WAIT) && avl.readdatavalid),
    .fill_data  (avl.readdata),
    .wr_en      ((state == WR_CMD) && !avl.waitrequest),
    .wr_data    (avl.writedata),
    .wr_be      (avl.byteenable),
    .hit_c      (hit_c),
    .line_c     (buf_line)
  );
`else
  assign hit_c    = 1'b0;
  assign buf_line = '0;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state          <= IDLE;
      lane_q         <= '0;
      cpu.ready      <= 1'b1;
      cpu.done       <= 1'b0;
      cpu.rdata      <= '0;
      avl.read       <= 1'b0;
      avl.write      <= 1'b0;
      avl.address    <= '0;
      avl.writedata  <= '0;
      avl.byteenable <= '0;
    end else begin
      cpu.done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu.valid && cpu.ready) begin
            lane_q    <= cpu.addr[3:2];
            cpu.ready <= 1'b0;
            if (cpu.we) begin
              avl.address    <= cpu.addr[ADDR_W+3:4];
              avl.writedata  <= {(DATA_W/CPU_W){cpu.wdata}};
              avl.byteenable <= lane_be(cpu.be, cpu.addr[3:2]);
              avl.write      <= 1'b1;
              state          <= WR_CMD;
            end else if (hit_c) begin
              // Buffered line: answer locally without touching the bus.
              cpu.rdata <= lane_word(buf_line, cpu.addr[3:2]);
              cpu.done  <= 1'b1;
              state     <= DONE;
            end else begin
              avl.address    <= cpu.addr[ADDR_W+3:4];
              avl.byteenable <= {BE_W{1'b1}};
              avl.read       <= 1'b1;
              state          <= RD_CMD;
            end
          end
        end
        WR_CMD: begin
          if (!avl.waitrequest) begin
            avl.write <= 1'b0;
            cpu.done  <= 1'b1;
            state     <= DONE;
          end
        end
        RD_CMD: begin
          if (!avl.waitrequest) begin
            avl.read <= 1'b0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (avl.readdatavalid) begin
            cpu.rdata <= lane_word(avl.readdata, lane_q);
            cpu.done  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          cpu.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cpu.ready <= 1'b1;
          avl.read  <= 1'b0;
          avl.write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_word_bridge.sv
// Directed self-checking bench for ddr3_word_bridge (LINE_BUF_EN scenario included when defined).
module tb_ddr3_word_bridge;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  cpu_word_if cpu_bus ();
  avl_mm_if #(.ADDR_W(26), .DATA_W(128)) avl_bus ();

  ddr3_word_bridge #(.ADDR_W(26), .DATA_W(128)) dut (
    .iCLK (clk),
    .iRST (rst),
    .cpu  (cpu_bus),
    .avl  (avl_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request at a negedge once ready is seen, hold it for one edge.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    for (int i = 0; i < 10; i++) begin
      if (cpu_bus.ready) break;
      @(negedge clk);
    end
    cpu_bus.we    = we;
    cpu_bus.addr  = addr;
    cpu_bus.wdata = wdata;
    cpu_bus.be    = be;
    cpu_bus.valid = 1'b1;
    @(negedge clk);
    cpu_bus.valid = 1'b0;
  endtask

  // Stall the read command for 'stall' cycles; returns how long avl_read stayed high.
  task automatic run_read_cmd(input int stall, output int rd_cycles);
    rd_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (avl_bus.read) begin
        rd_cycles++;
        avl_bus.waitrequest = (rd_cycles <= stall);
      end else if (rd_cycles != 0) begin
        break;
      end
      @(negedge clk);
    end
    avl_bus.waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cpu_bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cpu_bus.ready); end
    checks++; if (cpu_bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", cpu_bus.done); end
    checks++; if ({avl_bus.read, avl_bus.write} !== 2'b00) begin errors++; $display("FAIL reset_cmds: got %b want 00", {avl_bus.read, avl_bus.write}); end
    checks++; if (avl_bus.address !== 26'h0 || avl_bus.byteenable !== 16'h0) begin errors++; $display("FAIL reset_addr_be: got %h/%h want 0/0", avl_bus.address, avl_bus.byteenable); end
    checks++; if (avl_bus.writedata !== 128'h0 || cpu_bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_data: got %h/%h want 0/0", avl_bus.writedata, cpu_bus.rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_basic();
    avl_bus.waitrequest = 1'b0;
    issue(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
    checks++; if (avl_bus.write !== 1'b1 || avl_bus.read !== 1'b0) begin errors++; $display("FAIL st_cmd_c1: got w=%b r=%b want w=1 r=0", avl_bus.write, avl_bus.read); end
    checks++; if (avl_bus.address !== 26'h4) begin errors++; $display("FAIL st_addr: got %h want 4", avl_bus.address); end
    checks++; if (avl_bus.byteenable !== 16'h000F) begin errors++; $display("FAIL st_be: got %h want 000f", avl_bus.byteenable); end
    checks++; if (avl_bus.writedata !== {4{32'hDEAD_BEEF}}) begin errors++; $display("FAIL st_wdata: got %h want %h", avl_bus.writedata, {4{32'hDEAD_BEEF}}); end
    checks++; if (cpu_bus.ready !== 1'b0 || cpu_bus.done !== 1'b0) begin errors++; $display("FAIL st_c1_hs: got rdy=%b done=%b want 0 0", cpu_bus.ready, cpu_bus.done); end
    @(negedge clk);
    checks++; if (cpu_bus.done !== 1'b1 || avl_bus.write !== 1'b0) begin errors++; $display("FAIL st_c2: got done=%b w=%b want 1 0", cpu_bus.done, avl_bus.write); end
    @(negedge clk);
    checks++; if (cpu_bus.done !== 1'b0 || cpu_bus.ready !== 1'b1) begin errors++; $display("FAIL st_c3: got done=%b rdy=%b want 0 1", cpu_bus.done, cpu_bus.ready); end
  endtask

  task automatic test_load_stall();
    int rd_cycles;
    avl_bus.waitrequest = 1'b1;
    issue(1'b0, 32'h0000_0048, 32'h0, 4'h0);
    checks++; if (avl_bus.address !== 26'h4 || avl_bus.byteenable !== 16'hFFFF) begin errors++; $display("FAIL ld_addr_be: got %h/%h want 4/ffff", avl_bus.address, avl_bus.byteenable); end
    checks++; if (avl_bus.write !== 1'b0) begin errors++; $display("FAIL ld_no_write: got %b want 0", avl_bus.write); end
    run_read_cmd(3, rd_cycles);
    checks++; if (rd_cycles !== 4) begin errors++; $display("FAIL ld_read_len: got %0d want 4", rd_cycles); end
    repeat (4) begin
      checks++; if (cpu_bus.done !== 1'b0) begin errors++; $display("FAIL ld_early_done: got %b want 0", cpu_bus.done); end
      @(negedge clk);
    end
    avl_bus.readdata = {32'hAAAA_0003, 32'h1234_5678, 32'hAAAA_0001, 32'hAAAA_0000};
    avl_bus.readdatavalid = 1'b1;
    @(negedge clk);
    avl_bus.readdatavalid = 1'b0;
    checks++; if (cpu_bus.done !== 1'b1 || cpu_bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL ld_rdata: got done=%b %h want 1 12345678", cpu_bus.done, cpu_bus.rdata); end
    @(negedge clk);
    checks++; if (cpu_bus.done !== 1'b0 || cpu_bus.ready !== 1'b1) begin errors++; $display("FAIL ld_after: got done=%b rdy=%b want 0 1", cpu_bus.done, cpu_bus.ready); end
  endtask

  task automatic test_store_lane3_hold();
    avl_bus.waitrequest = 1'b1;
    issue(1'b1, 32'h0000_000C, 32'hCAFE_F00D, 4'b0110);
    checks++; if (avl_bus.byteenable !== 16'h6000 || avl_bus.address !== 26'h0) begin errors++; $display("FAIL st3_be: got %h/%h want 6000/0", avl_bus.byteenable, avl_bus.address); end
    @(negedge clk);
    checks++; if (avl_bus.write !== 1'b1 || avl_bus.byteenable !== 16'h6000 || avl_bus.writedata !== {4{32'hCAFE_F00D}}) begin errors++; $display("FAIL st3_hold: got w=%b be=%h wd=%h", avl_bus.write, avl_bus.byteenable, avl_bus.writedata); end
    checks++; if (cpu_bus.done !== 1'b0) begin errors++; $display("FAIL st3_stall_done: got %b want 0", cpu_bus.done); end
    avl_bus.waitrequest = 1'b0;
    @(negedge clk);
    checks++; if (cpu_bus.done !== 1'b1 || avl_bus.write !== 1'b0) begin errors++; $display("FAIL st3_done: got done=%b w=%b want 1 0", cpu_bus.done, avl_bus.write); end
    @(negedge clk);
  endtask

  task automatic test_alias();
    issue(1'b1, 32'hC000_0044, 32'h0102_0304, 4'b1000);
    checks++; if (avl_bus.address !== 26'h4 || avl_bus.byteenable !== 16'h0080) begin errors++; $display("FAIL alias: got %h/%h want 4/0080", avl_bus.address, avl_bus.byteenable); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious_rdv();
    int rd_cycles;
    avl_bus.readdata = {4{32'hBAD0_BAD0}};
    avl_bus.readdatavalid = 1'b1;
    @(negedge clk);
    avl_bus.readdatavalid = 1'b0;
    @(negedge clk);
    checks++; if (cpu_bus.done !== 1'b0 || cpu_bus.ready !== 1'b1) begin errors++; $display("FAIL spur_idle: got done=%b rdy=%b want 0 1", cpu_bus.done, cpu_bus.ready); end
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    run_read_cmd(0, rd_cycles);
    checks++; if (rd_cycles !== 1) begin errors++; $display("FAIL spur_read_len: got %0d want 1", rd_cycles); end
    avl_bus.readdata = {32'h3333_3333, 32'h2222_2222, 32'h0BAD_F00D, 32'h0000_1111};
    avl_bus.readdatavalid = 1'b1;
    @(negedge clk);
    avl_bus.readdatavalid = 1'b0;
    checks++; if (cpu_bus.done !== 1'b1 || cpu_bus.rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL spur_load: got done=%b %h want 1 0badf00d", cpu_bus.done, cpu_bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_rd_wait();
    int rd_cycles;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    run_read_cmd(0, rd_cycles);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (cpu_bus.ready !== 1'b1 || avl_bus.read !== 1'b0 || cpu_bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid: got rdy=%b r=%b done=%b want 1 0 0", cpu_bus.ready, avl_bus.read, cpu_bus.done); end
    avl_bus.readdata = {4{32'h5555_AAAA}};
    avl_bus.readdatavalid = 1'b1;
    @(negedge clk);
    avl_bus.readdatavalid = 1'b0;
    checks++; if (cpu_bus.done !== 1'b0 || cpu_bus.ready !== 1'b1) begin errors++; $display("FAIL rst_late_rdv: got done=%b rdy=%b want 0 1", cpu_bus.done, cpu_bus.ready); end
  endtask

`ifdef LINE_BUF_EN
  task automatic test_line_buf();
    int rd_cycles;
    issue(1'b0, 32'h0000_0080, 32'h0, 4'h0);
    run_read_cmd(0, rd_cycles);
    checks++; if (rd_cycles !== 1) begin errors++; $display("FAIL lb_miss_read: got %0d want 1", rd_cycles); end
    avl_bus.readdata = {32'h0F0E_0D0C, 32'h0B0A_0908, 32'hFEDC_BA98, 32'h7654_3210};
    avl_bus.readdatavalid = 1'b1;
    @(negedge clk);
    avl_bus.readdatavalid = 1'b0;
    checks++; if (cpu_bus.rdata !== 32'h7654_3210) begin errors++; $display("FAIL lb_miss_data: got %h want 76543210", cpu_bus.rdata); end
    @(negedge clk);
    issue(1'b1, 32'h0000_0081, 32'h0000_AA00, 4'b0010);
    checks++; if (avl_bus.byteenable !== 16'h0002 || avl_bus.address !== 26'h8) begin errors++; $display("FAIL lb_store: got %h/%h want 0002/8", avl_bus.byteenable, avl_bus.address); end
    repeat (2) @(negedge clk);
    issue(1'b0, 32'h0000_0084, 32'h0, 4'h0);
    checks++; if (avl_bus.read !== 1'b0 || cpu_bus.done !== 1'b1 || cpu_bus.rdata !== 32'hFEDC_BA98) begin errors++; $display("FAIL lb_hit: got r=%b done=%b %h want 0 1 fedcba98", avl_bus.read, cpu_bus.done, cpu_bus.rdata); end
    @(negedge clk);
    issue(1'b0, 32'h0000_0080, 32'h0, 4'h0);
    checks++; if (avl_bus.read !== 1'b0 || cpu_bus.done !== 1'b1 || cpu_bus.rdata !== 32'h7654_AA10) begin errors++; $display("FAIL lb_merge: got r=%b done=%b %h want 0 1 7654aa10", avl_bus.read, cpu_bus.done, cpu_bus.rdata); end
    @(negedge clk);
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    cpu_bus.valid = 1'b0;
    cpu_bus.we    = 1'b0;
    cpu_bus.addr  = 32'h0;
    cpu_bus.wdata = 32'h0;
    cpu_bus.be    = 4'h0;
    avl_bus.waitrequest   = 1'b0;
    avl_bus.readdatavalid = 1'b0;
    avl_bus.readdata      = 128'h0;
    test_reset();
    test_store_basic();
    test_load_stall();
    test_store_lane3_hold();
    test_alias();
    test_spurious_rdv();
    test_reset_in_rd_wait();
`ifdef LINE_BUF_EN
    test_line_buf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
